// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// registered valid/frame_err pulses and break detection.
module uart_receiver #(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CntDiv  = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HalfDiv = CntDiv / 2;
    localparam int unsigned CntW    = (CntDiv > 1) ? $clog2(CntDiv) : 1;

    localparam logic [CntW-1:0] CntLast  = CntW'(CntDiv - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HalfDiv - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    logic            rx_meta_q;
    logic            rx_s_q;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            frame_err_q, frame_err_d;

    // Synchronizer resets to the idle level so a release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RxD;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                // Half-period check rejects short glitches and centres later samples.
                if (cnt_q == HalfLast) begin
                    if (!rx_s_q) begin
                        state_d   = StData;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    shift_d[bit_idx_q] = rx_s_q;
                    cnt_d              = '0;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StBreak: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate in baud.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 RxD  input  1  serial input, asynchronous to clk; idle high; 8N1 frames, LSB first.
REQ-006 data  output  8  last correctly received byte; holds its value until the next valid frame.
REQ-007 valid  output  1  one-cycle pulse marking a new byte on data.
REQ-008 frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-009 busy  output  1  high in every state other than IDLE.

Function
REQ-010 CNT_DIV SHALL equal CLK_FREQ/BAUD_RATE (integer division); HALF_DIV SHALL equal CNT_DIV/2.
REQ-011 The baud counter SHALL be wide enough to hold CNT_DIV-1 for the chosen parameters, with no wrap inside a bit period.
REQ-012 RxD SHALL pass through a 2-flop synchronizer (reset value 1) before any use; rx_s denotes the synchronizer output.
REQ-013 The block SHALL have five states: IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: on rx_s==0, go to START and clear the counter; otherwise remain in IDLE.
REQ-015 START: when the counter reaches HALF_DIV-1, re-sample rx_s.
  - rx_s==0: go to DATA, clear the counter and the bit index.
  - rx_s==1: treat it as a glitch and return to IDLE with no output pulse.
REQ-016 DATA: when the counter reaches CNT_DIV-1, shift rx_s into the shift register LSB-first (bit index n goes to bit n), clear the counter, and increment the bit index.
REQ-017 DATA: after the 8th sample (bit index 7), go to STOP.
REQ-018 STOP: when the counter reaches CNT_DIV-1, sample rx_s.
  - rx_s==1: load data from the shift register, pulse valid for exactly one cycle, go to IDLE.
  - rx_s==0: leave data unchanged, pulse frame_err for exactly one cycle, go to BREAK.
REQ-019 BREAK: remain until rx_s==1, then go to IDLE; a held-low line SHALL produce exactly one frame_err.
REQ-020 valid and frame_err SHALL be registered, never both high in the same cycle, and never high outside the cycle following the STOP sample.
REQ-021 Latency: the valid pulse SHALL occur 9*CNT_DIV + HALF_DIV cycles (+/-3 for synchronizer and registering) after the RxD falling edge of the start bit.
REQ-022 A new start bit arriving in the cycle after the STOP sample SHALL be accepted (back-to-back frames, no idle gap required).
REQ-023 RxD activity in START/DATA/STOP other than the mid-bit sample points SHALL have no effect.

Reset
REQ-024 While rst is high the block SHALL be in IDLE, with:
  - counter and bit index 0;
  - shift register and data 8'h00;
  - valid, frame_err and busy 0;
  - synchronizer flops 1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no valid or frame_err pulse; after release, reception SHALL restart only on a fresh low level at rx_s.

Verification
REQ-026 The bench SHALL use CLK_FREQ=160000 and BAUD_RATE=10000 (CNT_DIV=16, HALF_DIV=8) and SHALL cover the following scenarios:
  - Frame 0x55 with stop bit 1 -> data=8'h55, a single valid pulse ~152 cycles after the start edge, frame_err never high.
  - Frames 0xA3 then 0x0F, back-to-back with no gap -> two valid pulses, data=8'hA3 then 8'h0F.
  - 4-cycle low glitch on an idle line -> returns to IDLE after ~8 cycles, no pulses, data unchanged.
  - Frame 0xFF with stop bit 0 and line held low for 50 bit times -> exactly one frame_err, data unchanged, busy held until the line returns high.
  - rst pulsed at data bit 4 of frame 0x3C -> no pulses; a following frame 0xC3 is received correctly.
  - Frame 0x81 with 1-cycle glitches injected at bit edges -> data=8'h81.
